// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and Booth recoder for the radix-4 multiplier
package mul_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} mul_state_t;

  typedef enum logic [2:0] {ZERO, P1, P2, M1, M2} booth_digit_t;

  // Bit triple is {a[2i+1], a[2i], a[2i-1]}.
  function automatic booth_digit_t booth_recode(input logic [2:0] bits);
    booth_digit_t d;
    case (bits)
      3'b001, 3'b010: d = P1;
      3'b011:         d = P2;
      3'b100:         d = M2;
      3'b101, 3'b110: d = M1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_pp.sv
// rtl/booth_r4_pp.sv - radix-4 Booth partial product select (B/2B, invert +1)
module booth_r4_pp
  import mul_pkg::*;
#(
  parameter int W = 10
) (
  input  booth_digit_t   digit,
  input  logic [W-1:0]   b_ext,
  output logic [W-1:0]   pp
);

  logic [W-1:0] mag;
  logic         neg;

  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (digit)
      P1: mag = b_ext;
      P2: mag = {b_ext[W-2:0], 1'b0};
      M1: begin
        mag = b_ext;
        neg = 1'b1;
      end
      M2: begin
        mag = {b_ext[W-2:0], 1'b0};
        neg = 1'b1;
      end
      default: mag = '0;
    endcase
    pp = neg ? (~mag + W'(1)) : mag;
  end

endmodule

// File: rtl/booth_r4_mul_seq.sv
// rtl/booth_r4_mul_seq.sv - sequential radix-4 Booth multiplier, signed/unsigned per operation
module booth_r4_mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int N_ITER = WIDTH / 2 + 1;
  localparam int XW     = WIDTH + 2;
  localparam int CW     = $clog2(N_ITER);

  if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_width_check
    $error("booth_r4_mul_seq: WIDTH must be even and >= 4");
  end

  mul_state_t      state, state_next;
  logic [CW-1:0]   iter;
  logic [2*XW-1:0] acc, acc_next;
  logic            a_prev;
  logic [XW-1:0]   b_ext, pp, hi_sum;
  booth_digit_t    digit;
  logic            accept, last;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (state == CALC) && (iter == CW'(N_ITER - 1));

  // acc = {upper partial sum, remaining multiplier bits}; two bits retire per shift.
  assign digit    = booth_recode({acc[1:0], a_prev});
  assign hi_sum   = acc[2*XW-1:XW] + pp;
  assign acc_next = $signed({hi_sum, acc[XW-1:0]}) >>> 2;

  booth_r4_pp #(.W(XW)) u_pp (
    .digit (digit),
    .b_ext (b_ext),
    .pp    (pp)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last) state_next = DONE;
      DONE:    state_next = start ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      iter    <= '0;
      acc     <= '0;
      a_prev  <= 1'b0;
      b_ext   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == CALC);
      done  <= (state_next == DONE);
      if (accept) begin
        // Two extra bits let unsigned operands ride through the signed datapath.
        acc    <= {{XW{1'b0}}, {2{is_signed & multiplier[WIDTH-1]}}, multiplier};
        b_ext  <= {{2{is_signed & multiplicand[WIDTH-1]}}, multiplicand};
        iter   <= '0;
        a_prev <= 1'b0;
      end else if (state == CALC) begin
        acc    <= acc_next;
        a_prev <= acc[1];
        iter   <= iter + CW'(1);
        if (last) product <= acc_next[2*WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_booth_r4_mul_seq.sv
// tb/tb_booth_r4_mul_seq.sv - directed and random checks of booth_r4_mul_seq at WIDTH 8 and 16
module tb_booth_r4_mul_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        start8 = 1'b0, s8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] p8;
  logic        busy8, done8;

  logic        start16 = 1'b0, s16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] p16;
  logic        busy16, done16;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  booth_r4_mul_seq #(.WIDTH(8)) dut8 (
    .clk (clk), .reset_n (reset_n), .start (start8), .is_signed (s8),
    .multiplier (a8), .multiplicand (b8), .product (p8), .busy (busy8), .done (done8)
  );

  booth_r4_mul_seq #(.WIDTH(16)) dut16 (
    .clk (clk), .reset_n (reset_n), .start (start16), .is_signed (s16),
    .multiplier (a16), .multiplicand (b16), .product (p16), .busy (busy16), .done (done16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one 8-bit operation; operands are scrambled after acceptance.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic [15:0] exp, input string tag);
    int n, nb;
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; s8 = s;
    @(negedge clk);
    start8 = 1'b0; a8 = ~a; b8 = ~b; s8 = ~s;
    n = 0;
    nb = busy8;
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
      nb += busy8;
    end
    check({tag, " latency"}, n, 5);
    check({tag, " busy_cycles"}, nb, 5);
    check({tag, " product"}, p8, exp);
    @(negedge clk);
    check({tag, " done_drop"}, done8, 1'b0);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s, input string tag);
    int n;
    logic [31:0] exp;
    exp = s ? ({{16{a[15]}}, a} * {{16{b[15]}}, b}) : ({16'b0, a} * {16'b0, b});
    @(negedge clk);
    start16 = 1'b1; a16 = a; b16 = b; s16 = s;
    @(negedge clk);
    start16 = 1'b0; a16 = ~a; s16 = ~s;
    n = 0;
    while (!done16 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, 9);
    check({tag, " product"}, p16, exp);
  endtask

  initial begin
    int n, nd;
    logic [15:0] held;

    repeat (3) @(negedge clk);
    check("reset product8", p8, 16'h0000);
    check("reset busy8", busy8, 1'b0);
    check("reset done8", done8, 1'b0);
    check("reset product16", p16, 32'h0);
    reset_n = 1'b1;

    // T1..T3 directed 8-bit vectors
    op8(8'd5, 8'd6, 1'b1, 16'h001E, "t1_5x6");
    op8(8'h80, 8'h80, 1'b1, 16'h4000, "t2_m128xm128");
    op8(8'hF9, 8'h08, 1'b1, 16'hFFC8, "t2_m7x8");
    op8(8'h7F, 8'h80, 1'b1, 16'hC080, "t2_127xm128");
    op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "t3_255x255u");
    op8(8'hFF, 8'hFF, 1'b1, 16'h0001, "t3_m1xm1s");
    op8(8'd200, 8'd3, 1'b0, 16'h0258, "u_200x3");
    op8(8'd0, 8'hFB, 1'b1, 16'h0000, "zero_x_m5");

    // T4 start re-pulsed mid-CALC is ignored
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd12; b8 = 8'd11; s8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd100; b8 = 8'd100; s8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) nd++;
    end
    check("t4 done_count", nd, 1);
    check("t4 product", p8, 16'h0084);

    // T5 reset mid-CALC aborts
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd3; b8 = 8'd4; s8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t5 rst product", p8, 16'h0000);
    check("t5 rst busy", busy8, 1'b0);
    check("t5 rst done", done8, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done8 || busy8) nd++;
    end
    check("t5 no_activity", nd, 0);
    op8(8'd3, 8'd3, 1'b0, 16'h0009, "t5_3x3");

    // Back-to-back start in the DONE cycle
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd5; b8 = 8'd6; s8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b first product", p8, 16'h001E);
    held = p8;
    start8 = 1'b1; a8 = 8'd7; b8 = 8'hFD; s8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("b2b done_drop", done8, 1'b0);
    check("b2b busy", busy8, 1'b1);
    check("b2b product_held", p8, held);
    n = 0;
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b latency", n, 5);
    check("b2b product", p8, 16'hFFEB);

    // T6 WIDTH=16 corners and random
    op16(16'h8000, 16'h8000, 1'b1, "w16 min_x_min");
    op16(16'hFFFF, 16'hFFFF, 1'b0, "w16 max_u_sq");
    op16(16'h7FFF, 16'h8000, 1'b1, "w16 max_x_min");
    op16(16'h0000, 16'hFFFF, 1'b0, "w16 zero");
    op16(16'hFFFF, 16'h0001, 1'b1, "w16 m1_x_1");
    for (int i = 0; i < 300; i++) begin
      if (mismatched >= 5) break;
      op16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), "w16 random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
